// File: rtl/rgb2gray_stream.sv
// rtl/rgb2gray_stream.sv - streaming RGB888 to 8-bit luma converter, 3-stage global-stall pipeline
module rgb2gray_stream #(
  parameter int unsigned COEF_W = 14,
  parameter int unsigned COEF_R = 4899,
  parameter int unsigned COEF_G = 9617,
  parameter int unsigned COEF_B = 1868
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [23:0] s_data,
  input  logic        s_user,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_user,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] frame_cnt
);
  localparam int unsigned PW = 8 + COEF_W;
  localparam int unsigned SW = 10 + COEF_W;
  localparam logic [PW-1:0] LP_CR = PW'(COEF_R);
  localparam logic [PW-1:0] LP_CG = PW'(COEF_G);
  localparam logic [PW-1:0] LP_CB = PW'(COEF_B);
  localparam logic [SW-1:0] LP_HALF = SW'(1) << (COEF_W - 1);

  logic          w_en;
  logic [7:0]    r_r, r_g, r_b;
  logic          r_u1, r_l1, r_v1;
  logic [PW-1:0] r_pr, r_pg, r_pb;
  logic          r_u2, r_l2, r_v2;
  logic [7:0]    r_m_data;
  logic          r_m_user, r_m_last, r_m_valid;
  logic [15:0]   r_frame_cnt;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_y;
  logic [7:0]    w_y8;

  // One enable for every stage: a stalled output freezes the whole pipe, bubbles included.
  assign w_en    = ~r_m_valid | m_ready;
  assign s_ready = w_en;

  assign w_sum = SW'(r_pr) + SW'(r_pg) + SW'(r_pb) + LP_HALF;
  assign w_y   = w_sum >> COEF_W;
  assign w_y8  = (|w_y[SW-1:8]) ? 8'hFF : w_y[7:0];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_u1        <= 1'b0;
      r_l1        <= 1'b0;
      r_v1        <= 1'b0;
      r_pr        <= '0;
      r_pg        <= '0;
      r_pb        <= '0;
      r_u2        <= 1'b0;
      r_l2        <= 1'b0;
      r_v2        <= 1'b0;
      r_m_data    <= '0;
      r_m_user    <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_valid   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_en) begin
        r_r       <= s_data[23:16];
        r_g       <= s_data[15:8];
        r_b       <= s_data[7:0];
        r_u1      <= s_user;
        r_l1      <= s_last;
        r_v1      <= s_valid;
        r_pr      <= PW'(r_r) * LP_CR;
        r_pg      <= PW'(r_g) * LP_CG;
        r_pb      <= PW'(r_b) * LP_CB;
        r_u2      <= r_u1;
        r_l2      <= r_l1;
        r_v2      <= r_v1;
        r_m_data  <= w_y8;
        r_m_user  <= r_u2;
        r_m_last  <= r_l2;
        r_m_valid <= r_v2;
      end
      if (r_m_valid & m_ready & r_m_user) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign m_data    = r_m_data;
  assign m_user    = r_m_user;
  assign m_last    = r_m_last;
  assign m_valid   = r_m_valid;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb/tb_rgb2gray_stream.sv - self-checking bench for rgb2gray_stream
module tb_rgb2gray_stream;
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [23:0] s_data;
  logic        s_user, s_last, s_valid, m_ready;
  logic        s_ready, m_user, m_last, m_valid;
  logic [7:0]  m_data;
  logic [15:0] frame_cnt;
  logic        x_s_ready, x_m_user, x_m_last, x_m_valid;
  logic [7:0]  x_m_data;
  logic [15:0] x_frame_cnt;

  always #5 ap_clk = ~ap_clk;

  rgb2gray_stream u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_data(s_data), .s_user(s_user), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_user(m_user), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_cnt(frame_cnt)
  );

  rgb2gray_stream #(.COEF_W(14), .COEF_R(8192), .COEF_G(8192), .COEF_B(8192)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_data(s_data), .s_user(s_user), .s_last(s_last),
    .s_valid(s_valid), .s_ready(x_s_ready), .m_data(x_m_data), .m_user(x_m_user), .m_last(x_m_last),
    .m_valid(x_m_valid), .m_ready(m_ready), .frame_cnt(x_frame_cnt)
  );

  typedef struct { logic [23:0] data; logic user; logic last; } beat_t;
  typedef struct { logic [7:0] y; logic user; logic last; int cyc; } exp_t;
  typedef struct { logic [23:0] data; logic [7:0] y; } vec_t;

  beat_t      in_q[$];
  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_seq[$];
  vec_t       tbl[7];
  int n_chk = 0;
  int n_fail = 0;
  int fc_exp = 0;

  // Luma from the weighted-sum definition, rounded half-up, clipped to 8 bits.
  function automatic logic [7:0] ref_y(input logic [23:0] d, input int cr, input int cg, input int cb);
    int unsigned acc;
    acc = int'(d[23:16]) * cr + int'(d[15:8]) * cg + int'(d[7:0]) * cb + 8192;
    acc = acc / 16384;
    return (acc > 255) ? 8'hFF : acc[7:0];
  endfunction

  task automatic check_eq(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input int mode, input bit chk_lat, input bit gaps);
    int    cyc = 0;
    bit    prev_stall = 0;
    bit    pend = 0;
    bit    in_fire, out_fire;
    logic [7:0] pd = 0;
    logic  pu = 0, pl = 0;
    exp_t  e, ne;
    beat_t b;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge ap_clk);
      check_eq("frame_cnt", frame_cnt, fc_exp);
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_hold", {m_user, m_last, m_data}, {pu, pl, pd});
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (in_q.size() > 0 && (pend || !gaps || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_data  = in_q[0].data;
        s_user  = in_q[0].user;
        s_last  = in_q[0].last;
      end else begin
        s_valid = 1'b0;
        s_data  = 24'($urandom);
        s_user  = 1'($urandom);
        s_last  = 1'($urandom);
      end
      #1;
      check_eq("s_ready", s_ready, !m_valid || m_ready);
      in_fire  = s_valid && s_ready;
      out_fire = m_valid && m_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_out_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("m_data", m_data, e.y);
          check_eq("m_user", m_user, e.user);
          check_eq("m_last", m_last, e.last);
          if (chk_lat) check_eq("latency", cyc - e.cyc, 3);
          got_q.push_back(m_data);
        end
        if (m_user) fc_exp = (fc_exp + 1) % 65536;
      end
      if (in_fire) begin
        b = in_q.pop_front();
        ne.y = ref_y(b.data, 4899, 9617, 1868);
        ne.user = b.user;
        ne.last = b.last;
        ne.cyc = cyc;
        exp_q.push_back(ne);
      end
      pend = s_valid && !s_ready;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pu = m_user;
      pl = m_last;
      cyc++;
    end
    if (cyc >= 3000) begin
      check_eq("drain_timeout", cyc, 0);
      in_q.delete();
      exp_q.delete();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic [23:0] seq_data[20];
    tbl[0] = '{24'h000000, 8'h00};
    tbl[1] = '{24'hFFFFFF, 8'hFF};
    tbl[2] = '{24'hFF0000, 8'h4C};
    tbl[3] = '{24'h00FF00, 8'h96};
    tbl[4] = '{24'h0000FF, 8'h1D};
    tbl[5] = '{24'h808080, 8'h80};
    tbl[6] = '{24'h102030, 8'h1D};

    ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_eq("rst_outputs", {m_valid, m_user, m_last, m_data}, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    #1;
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_m_valid_after", m_valid, 0);

    got_q.delete();
    for (int i = 0; i < 7; i++) in_q.push_back('{tbl[i].data, 1'b0, 1'b0});
    run(0, 1, 0);
    check_eq("tbl_count", got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) check_eq("tbl_y", got_q[i], tbl[i].y);

    for (int i = 0; i < 20; i++) seq_data[i] = 24'($urandom);
    got_q.delete();
    for (int i = 0; i < 20; i++) in_q.push_back('{seq_data[i], 1'b0, 1'b0});
    run(0, 1, 0);
    ref_seq = got_q;
    got_q.delete();
    for (int i = 0; i < 20; i++) in_q.push_back('{seq_data[i], 1'b0, 1'b0});
    run(1, 0, 0);
    check_eq("toggle_count", got_q.size(), 20);
    for (int i = 0; i < 20 && i < got_q.size() && i < ref_seq.size(); i++)
      check_eq("toggle_seq", got_q[i], ref_seq[i]);

    for (int i = 0; i < 6; i++) in_q.push_back('{24'($urandom), i == 0, i == 3});
    run(0, 1, 0);
    @(negedge ap_clk);
    check_eq("frame_cnt_after_sof", frame_cnt, 1);

    for (int i = 0; i < 200; i++) begin
      b.data = 24'($urandom);
      b.user = ($urandom_range(0, 15) == 0);
      b.last = ($urandom_range(0, 7) == 0);
      in_q.push_back(b);
    end
    run(2, 0, 1);

    @(negedge ap_clk);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 24'($urandom); s_user = 1'b1; s_last = 1'b1;
      @(negedge ap_clk);
    end
    s_valid = 1'b0;
    check_eq("inflight_valid", m_valid, 1);
    check_eq("inflight_cnt_nonzero", frame_cnt != 0, 1);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check_eq("async_rst_m_valid", m_valid, 0);
    check_eq("async_rst_frame_cnt", frame_cnt, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    fc_exp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk);
      check_eq("no_beat_after_rst", m_valid, 0);
    end

    s_valid = 1'b1; s_data = 24'hFFFFFF; s_user = 1'b0; s_last = 1'b0;
    @(negedge ap_clk);
    s_data = 24'h808080;
    @(negedge ap_clk);
    s_valid = 1'b0;
    @(negedge ap_clk);
    check_eq("sat_valid", x_m_valid, 1);
    check_eq("sat_ffffff", x_m_data, 8'hFF);
    @(negedge ap_clk);
    check_eq("sat_808080", x_m_data, ref_y(24'h808080, 8192, 8192, 8192));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
